// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player Spacewar score tracker driving a 4-digit decimal display
// Hits are edge-detected, rate-limited by a per-player holdoff and credited only while in PLAY.
module score_keeper #(
  parameter int WIN_SCORE      = 10,
  parameter int HOLDOFF_CYCLES = 25_000_000,
  parameter int HOLD_W         = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_p1,
  input  logic        hit_p2,
  input  logic        new_game,
  output logic [15:0] display_number,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [6:0]        WIN       = 7'(WIN_SCORE);

  state_t            state_q, state_d;
  logic              hit_p1_q, hit_p2_q;
  logic [HOLD_W-1:0] hold_p1_q, hold_p1_d;
  logic [HOLD_W-1:0] hold_p2_q, hold_p2_d;
  logic [6:0]        score_p1_q, score_p1_d;
  logic [6:0]        score_p2_q, score_p2_d;
  logic [1:0]        winner_q, winner_d;
  logic [15:0]       disp_q, disp_d;

  logic rise_p1, rise_p2;
  logic credit_p1, credit_p2;
  logic reach_p1, reach_p2;

  assign rise_p1   = hit_p1 & ~hit_p1_q;
  assign rise_p2   = hit_p2 & ~hit_p2_q;
  assign credit_p1 = rise_p1 & (hold_p1_q == '0) & (state_q == S_PLAY) & ~new_game;
  assign credit_p2 = rise_p2 & (hold_p2_q == '0) & (state_q == S_PLAY) & ~new_game;
  assign reach_p1  = credit_p1 & ((score_p1_q + 7'd1) == WIN);
  assign reach_p2  = credit_p2 & ((score_p2_q + 7'd1) == WIN);

  always_comb begin
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    hold_p1_d  = hold_p1_q;
    hold_p2_d  = hold_p2_q;
    winner_d   = winner_q;
    if (new_game) begin
      score_p1_d = '0;
      score_p2_d = '0;
      hold_p1_d  = '0;
      hold_p2_d  = '0;
      winner_d   = '0;
    end else begin
      if (credit_p1) begin
        score_p1_d = score_p1_q + 7'd1;
        hold_p1_d  = HOLD_LOAD;
      end else if (hold_p1_q != '0) begin
        hold_p1_d = hold_p1_q - 1'b1;
      end
      if (credit_p2) begin
        score_p2_d = score_p2_q + 7'd1;
        hold_p2_d  = HOLD_LOAD;
      end else if (hold_p2_q != '0) begin
        hold_p2_d = hold_p2_q - 1'b1;
      end
      winner_d = winner_q | {reach_p2, reach_p1};
    end
  end

  // 100 = 64 + 32 + 4, so the display value is built from shifts and adds
  always_comb begin
    disp_d = ({9'd0, score_p1_q} << 6) + ({9'd0, score_p1_q} << 5)
           + ({9'd0, score_p1_q} << 2) + {9'd0, score_p2_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLAY: begin
        if (!new_game && (reach_p1 || reach_p2)) state_d = S_OVER;
      end
      S_OVER: begin
        if (new_game) state_d = S_PLAY;
      end
      default: state_d = S_PLAY;
    endcase
  end

  always_comb begin
    game_over      = (state_q == S_OVER);
    winner         = winner_q;
    display_number = disp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
      hold_p1_q  <= '0;
      hold_p2_q  <= '0;
      score_p1_q <= '0;
      score_p2_q <= '0;
      winner_q   <= '0;
      disp_q     <= '0;
    end else begin
      hit_p1_q   <= hit_p1;
      hit_p2_q   <= hit_p2;
      hold_p1_q  <= hold_p1_d;
      hold_p2_q  <= hold_p2_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      winner_q   <= winner_d;
      disp_q     <= disp_d;
    end
  end

endmodule
